// File: rtl/basys_hex_input_pkg.sv
// Shared types and constants for the Basys front-panel hex entry block.
package basys_hex_input_pkg;

  localparam int HEX_DIGITS  = 4;
  localparam int WORD_W      = 16;
  localparam int DIGIT_CNT_W = 3;
  localparam int NUM_BTN     = 3;

  typedef enum logic [0:0] {ENTRY = 1'b0, HOLD = 1'b1} state_e;

  // Bit order matches the packed raw-button vector {clear, commit, enter}.
  typedef struct packed {
    logic clear;
    logic commit;
    logic enter;
  } btn_ev_t;

  function automatic logic [WORD_W-1:0] shift_digit(input logic [WORD_W-1:0] w,
                                                    input logic [3:0] d);
    return {w[WORD_W-5:0], d};
  endfunction

endpackage

// File: rtl/basys_hex_input_if.sv
// Valid/ready handshake carrying the committed word to the processor.
interface basys_hex_input_if;
  import basys_hex_input_pkg::*;

  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/basys_hex_input_debounce.sv
// Per-button 2-flop synchronizer, stability counter and rising-edge pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic real_clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level, level_d;

  always_ff @(posedge real_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], btn_raw};
      level_d <= level;
      // Any sample that agrees with the current level restarts the count.
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_d;
endmodule

// File: rtl/basys_hex_input.sv
// Front-panel hex entry: debounced buttons build a 16-bit word sent over valid/ready.
// Optional BASYS_HEX_INPUT_ECHO_EN adds display_word for the seven-segment path.
module basys_hex_input
  import basys_hex_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                   real_clk,
  input  logic                   reset_n,
  input  logic [3:0]             sw,
  input  logic                   btn_enter,
  input  logic                   btn_commit,
  input  logic                   btn_clear,
  output logic [DIGIT_CNT_W-1:0] digit_count,
  output logic                   overrun,
  basys_hex_input_if.master      hs
`ifdef BASYS_HEX_INPUT_ECHO_EN
  ,
  output logic [WORD_W-1:0]      display_word
`endif
);
  localparam logic [0:0] ST_ENTRY = ENTRY;
  localparam logic [0:0] ST_HOLD  = HOLD;

  logic [NUM_BTN-1:0] btn_raw, btn_rise;
  btn_ev_t            ev;
  logic [3:0]         sw_s1, sw_s2;
  logic [WORD_W-1:0]  entry_buf;
  logic [0:0]         state;

  assign btn_raw = {btn_clear, btn_commit, btn_enter};

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .real_clk (real_clk),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .rise     (btn_rise)
  );

  assign ev = btn_ev_t'(btn_rise);

  always_ff @(posedge real_clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge real_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_ENTRY;
      entry_buf     <= '0;
      digit_count   <= '0;
      overrun       <= 1'b0;
      hs.data_out   <= '0;
      hs.data_valid <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (hs.data_valid && hs.data_ready) begin
        hs.data_valid <= 1'b0;
        state         <= ST_ENTRY;
      end
      // One action per cycle: clear beats commit beats enter. A commit judged
      // in HOLD stays an overrun even if the pending word leaves this edge.
      if (ev.clear) begin
        entry_buf   <= '0;
        digit_count <= '0;
      end else if (ev.commit) begin
        if (state == ST_HOLD) begin
          overrun <= 1'b1;
        end else if (digit_count != '0) begin
          hs.data_out   <= entry_buf;
          hs.data_valid <= 1'b1;
          entry_buf     <= '0;
          digit_count   <= '0;
          state         <= ST_HOLD;
        end
      end else if (ev.enter) begin
        entry_buf <= shift_digit(entry_buf, sw_s2);
        if (digit_count != DIGIT_CNT_W'(HEX_DIGITS))
          digit_count <= digit_count + 1'b1;
      end
    end
  end

`ifdef BASYS_HEX_INPUT_ECHO_EN
  // While waiting on the CPU with nothing typed, keep showing the sent word.
  assign display_word = (state == ST_HOLD && digit_count == '0) ? hs.data_out : entry_buf;
`endif

endmodule

// File: tb/tb_basys_hex_input.sv
// Randomized self-checking bench for basys_hex_input against an event-level model.
module tb_basys_hex_input;
  logic        real_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic [3:0]  sw = '0;
  logic        btn_enter = 1'b0, btn_commit = 1'b0, btn_clear = 1'b0;
  logic [2:0]  digit_count;
  logic        overrun;
`ifdef BASYS_HEX_INPUT_ECHO_EN
  logic [15:0] display_word;
`endif

  basys_hex_input_if hif ();

  basys_hex_input #(.DEBOUNCE_CYCLES(4)) dut (
    .real_clk    (real_clk),
    .reset_n     (reset_n),
    .sw          (sw),
    .btn_enter   (btn_enter),
    .btn_commit  (btn_commit),
    .btn_clear   (btn_clear),
    .digit_count (digit_count),
    .overrun     (overrun),
    .hs          (hif.master)
`ifdef BASYS_HEX_INPUT_ECHO_EN
    ,
    .display_word(display_word)
`endif
  );

  always #5 real_clk = ~real_clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model: typed value, digit count, pending word, words expected on the bus.
  int m_ent, m_cnt, m_last, exp_ovr;
  bit m_pend;
  int exp_q[$];
  int obs_q[$];
  int ovr_cnt, valid_cycles;
  bit prev_hold;
  logic [15:0] prev_out;

  always @(negedge real_clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (hif.data_valid) valid_cycles++;
      if (hif.data_valid && hif.data_ready) obs_q.push_back(int'(hif.data_out));
      if (overrun) ovr_cnt++;
      if (prev_hold) begin
        chk("hold_valid", hif.data_valid, 1);
        chk("hold_data", hif.data_out, prev_out);
      end
      prev_hold = hif.data_valid && !hif.data_ready;
      prev_out  = hif.data_out;
    end
  end

  task automatic model_reset();
    m_ent = 0; m_cnt = 0; m_last = 0; m_pend = 0; exp_ovr = 0; ovr_cnt = 0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge real_clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  // m = {clear, commit, enter}
  task automatic model_act(input logic [2:0] m, input int d, input bit r);
    if (m[2]) begin
      m_ent = 0; m_cnt = 0;
    end else if (m[1]) begin
      if (m_pend) exp_ovr++;
      else if (m_cnt != 0) begin
        m_last = m_ent; m_pend = 1; m_ent = 0; m_cnt = 0;
        if (r) begin exp_q.push_back(m_last); m_pend = 0; end
      end
    end else if (m[0]) begin
      m_ent = ((m_ent * 16) + d) % 65536;
      if (m_cnt < 4) m_cnt++;
    end
  endtask

  task automatic press(input logic [2:0] m);
    @(posedge real_clk); #1;
    {btn_clear, btn_commit, btn_enter} = m;
    repeat (12) @(posedge real_clk); #1;
    {btn_clear, btn_commit, btn_enter} = 3'b000;
    repeat (12) @(posedge real_clk); #1;
  endtask

  task automatic compare(input string tag);
    int e, o;
    chk({tag, "_cnt"}, digit_count, m_cnt);
    chk({tag, "_valid"}, hif.data_valid, m_pend);
    chk({tag, "_dout"}, hif.data_out, m_last);
    chk({tag, "_ovr"}, ovr_cnt, exp_ovr);
    chk({tag, "_nxfer"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      chk({tag, "_xfer"}, o, e);
    end
    obs_q.delete(); exp_q.delete();
`ifdef BASYS_HEX_INPUT_ECHO_EN
    chk({tag, "_echo"}, display_word, (m_pend && m_cnt == 0) ? m_last : m_ent);
`endif
  endtask

  task automatic op(input string tag, input logic [2:0] m, input logic [3:0] d, input bit r);
    sw = d;
    hif.data_ready = r;
    if (m_pend && r) begin exp_q.push_back(m_last); m_pend = 0; end
    press(m);
    model_act(m, int'(d), r);
    repeat (2) @(posedge real_clk); #1;
    compare(tag);
  endtask

  initial begin
    logic [2:0] m;
    int k;
    hif.data_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", hif.data_valid, 0);
    chk("rst_dout", hif.data_out, 0);
    chk("rst_cnt", digit_count, 0);
    chk("rst_ovr", overrun, 0);
    do_reset();

    // Bounce rejection: chatter every 2 cycles, then a solid press.
    sw = 4'h6;
    for (int i = 0; i < 10; i++) begin
      btn_enter = ~btn_enter;
      repeat (2) @(posedge real_clk); #1;
    end
    press(3'b001);
    model_act(3'b001, 6, 0);
    repeat (2) @(posedge real_clk); #1;
    compare("bounce");
    chk("bounce_one", digit_count, 1);

    // Shift with overflow, then commit with the consumer ready.
    do_reset();
    for (int i = 1; i <= 5; i++) op("shift", 3'b001, 4'(i), 1'b0);
    chk("ovfl_buf", m_ent, 16'h2345);
    valid_cycles = 0;
    op("commit_rdy", 3'b010, 4'h0, 1'b1);
    chk("one_cycle_valid", valid_cycles, 1);

    // Back-pressure and overrun.
    op("bp_a", 3'b001, 4'hA, 1'b0);
    op("bp_b", 3'b001, 4'hB, 1'b0);
    op("bp_commit", 3'b010, 4'h0, 1'b0);
    chk("bp_word", hif.data_out, 16'h00AB);
    repeat (50) @(posedge real_clk); #1;
    op("bp_c", 3'b001, 4'hC, 1'b0);
    op("bp_ovr", 3'b010, 4'h0, 1'b0);
    chk("bp_ovr_cnt", ovr_cnt, 1);
    op("bp_drain", 3'b000, 4'h0, 1'b1);

    // Empty commit and clear+commit together.
    do_reset();
    op("empty_commit", 3'b010, 4'h0, 1'b1);
    op("ent_f", 3'b001, 4'hF, 1'b0);
    op("clr_commit", 3'b110, 4'h0, 1'b0);

    // Reset while a word is pending.
    for (int i = 1; i <= 4; i++) op("pre_rst", 3'b001, 4'(i), 1'b0);
    op("pre_rst_commit", 3'b010, 4'h0, 1'b0);
    chk("pend_word", hif.data_out, 16'h1234);
    @(posedge real_clk); #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", hif.data_valid, 0);
    chk("arst_dout", hif.data_out, 0);
    chk("arst_cnt", digit_count, 0);
    repeat (2) @(posedge real_clk); #1;
    reset_n = 1'b1;
    model_reset();
    op("post_rst_ent", 3'b001, 4'h5, 1'b0);
    op("post_rst_commit", 3'b010, 4'h0, 1'b1);

    // Echo sequence (also exercises HOLD entry while typing).
    do_reset();
    op("echo7", 3'b001, 4'h7, 1'b0);
    op("echo_commit", 3'b010, 4'h0, 1'b0);
    op("echo9", 3'b001, 4'h9, 1'b0);
    op("echo_drain", 3'b000, 4'h0, 1'b1);

    // Randomized operations, including combined presses.
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4)      m = 3'b001;
      else if (k < 6) m = 3'b010;
      else if (k < 7) m = 3'b100;
      else            m = 3'($urandom_range(0, 7));
      op("rand", m, 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
